// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM duty decoder: FSM states, counter width,
// default generator timing and a saturating counter helper.
package pwm_dec_pkg;

    localparam int CNT_W = 9;

    localparam int DEF_PERIOD_CYC  = 256;
    localparam int DEF_STEP_CYC    = 16;
    localparam int DEF_TOL_CYC     = 4;
    localparam int DEF_SYNC_STAGES = 2;

    localparam int TIMEOUT_CYC = DEF_PERIOD_CYC + DEF_TOL_CYC;
    localparam int HALF_STEP   = DEF_STEP_CYC / 2;

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// PWM input conditioning: SYNC_STAGES-flop synchronizer, optional 3-sample deglitch
// (PWM_DEGLITCH_EN, +2 cycles), 1-flop edge detector; no backpressure.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   s_d;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEGLITCH_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_lvl};
        end
    end

    // s_d is the previous filtered level, so s holds until three samples agree.
    assign s = (sync_lvl == hist_q[0] && sync_lvl == hist_q[1]) ? sync_lvl : s_d;
`else
    assign s = sync_lvl;
`endif

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the 4-bit duty code from a fixed-period PWM line; results appear SYNC_STAGES+1
// cycles after the closing rise (+2 with PWM_DEGLITCH_EN); no backpressure, pulses are fire-and-forget.
module pwm_duty_decoder
    import pwm_dec_pkg::*;
#(
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int STEP_CYC    = DEF_STEP_CYC,
    parameter int TOL_CYC     = DEF_TOL_CYC,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [3:0] duty_out,
    output logic       full_on,
    output logic       duty_valid,
    output logic       period_err
);

    localparam int STEP_SH = $clog2(STEP_CYC);
    localparam logic [CNT_W-1:0] HALF_V   = CNT_W'(STEP_CYC / 2);
    localparam logic [CNT_W-1:0] PER_MIN  = CNT_W'(PERIOD_CYC - TOL_CYC);
    localparam logic [CNT_W-1:0] PER_MAX  = CNT_W'(PERIOD_CYC + TOL_CYC);
    localparam logic [CNT_W-1:0] IDLE_TMO = CNT_W'(PERIOD_CYC + TOL_CYC - 1);

    logic s;
    logic rise;
    logic fall;

    pwm_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_50M(clk_50M),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    state_t           state;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             hi_run;

    logic [CNT_W-1:0] rnd_sum;
    logic [CNT_W-1:0] duty_raw;
    logic [3:0]       duty_code;
    logic             per_ok;

    // Round to nearest step in counter width; a full-length high time rounds to 16 and clamps.
    always_comb begin
        rnd_sum   = hi_cnt + HALF_V;
        duty_raw  = rnd_sum >> STEP_SH;
        duty_code = (duty_raw > CNT_W'(15)) ? 4'd15 : duty_raw[3:0];
        per_ok    = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX);
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            hi_run     <= 1'b0;
            duty_out   <= 4'd0;
            full_on    <= 1'b0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            period_err <= 1'b0;
            hi_run     <= rise | (hi_run & ~fall);

            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEAS;
                        hi_cnt  <= CNT_W'(1);
                        per_cnt <= CNT_W'(1);
                    end else if (per_cnt == IDLE_TMO) begin
                        duty_out   <= s ? 4'd15 : 4'd0;
                        full_on    <= s;
                        duty_valid <= 1'b1;
                        per_cnt    <= '0;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end

                MEAS: begin
                    if (rise) begin
                        if (per_ok) begin
                            duty_out   <= duty_code;
                            full_on    <= 1'b0;
                            duty_valid <= 1'b1;
                        end else begin
                            period_err <= 1'b1;
                        end
                        hi_cnt  <= CNT_W'(1);
                        per_cnt <= CNT_W'(1);
                    end else if (per_cnt >= PER_MAX) begin
                        // Line stopped toggling: report its level and fall back to IDLE.
                        duty_out   <= s ? 4'd15 : 4'd0;
                        full_on    <= s;
                        duty_valid <= 1'b1;
                        per_cnt    <= '0;
                        state      <= IDLE;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                        if (hi_run && !fall) begin
                            hi_cnt <= sat_inc(hi_cnt);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: segment-level reference model predicts each
// duty_valid/period_err event; a negedge monitor pops and compares.
module tb_pwm_duty_decoder;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       pwm_in  = 1'b0;
    logic [3:0] duty_out;
    logic       full_on;
    logic       duty_valid;
    logic       period_err;

    always #10 clk_50M = ~clk_50M;

    pwm_duty_decoder dut (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .full_on   (full_on),
        .duty_valid(duty_valid),
        .period_err(period_err)
    );

`ifdef PWM_DEGLITCH_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 2;
`endif
    localparam int NOM = 256;
    localparam int TOL = 4;
    localparam int TMO = NOM + TOL;

    typedef struct {
        bit is_err;
        int duty;
        bit full;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (time in input-sample cycles)
    int t_cur     = 0;
    int t_ref     = 0;
    bit meas_open = 0;
    bit prev_lvl  = 0;
    int hi        = 0;
    int held_duty = 0;
    bit held_full = 0;
    bit in_rst    = 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic push_valid(input int d, input bit f);
        exp_t e;
        held_duty = d;
        held_full = f;
        e.is_err = 0; e.duty = d; e.full = f;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1; e.duty = held_duty; e.full = held_full;
        q.push_back(e);
    endtask

    task automatic model_seg(input bit lvl, input int n);
        int p;
        int d;
        if (lvl && !prev_lvl) begin
            if (meas_open) begin
                p = t_cur - t_ref;
                if (p >= NOM - TOL && p <= NOM + TOL) begin
                    d = (hi + 8) / 16;
                    if (d > 15) d = 15;
                    push_valid(d, 0);
                end else begin
                    push_err();
                end
            end
            meas_open = 1;
            t_ref     = t_cur;
            hi        = 0;
        end
        if (lvl && meas_open) hi += n;
        while (t_ref + TMO < t_cur + n) begin
            push_valid(lvl ? 15 : 0, lvl);
            meas_open = 0;
            t_ref += TMO;
        end
        prev_lvl = lvl;
        t_cur += n;
    endtask

    task automatic drive_raw(input bit lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(posedge clk_50M);
        #2;
    endtask

    task automatic seg(input bit lvl, input int n);
        if (in_rst) t_cur += n;
        else model_seg(lvl, n);
        drive_raw(lvl, n);
    endtask

    task automatic per(input int h, input int p);
        seg(1'b1, h);
        seg(1'b0, p - h);
    endtask

    task automatic release_reset();
        reset     = 1'b0;
        in_rst    = 0;
        meas_open = 0;
        prev_lvl  = 0;
        hi        = 0;
        held_duty = 0;
        held_full = 0;
        t_ref     = t_cur - 1 - DLY;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_duty_out"}, int'(duty_out), 0);
        chk({tag, "_full_on"}, int'(full_on), 0);
        chk({tag, "_duty_valid"}, int'(duty_valid), 0);
        chk({tag, "_period_err"}, int'(period_err), 0);
    endtask

    always @(negedge clk_50M) begin
        exp_t e;
        if (!reset && (duty_valid || period_err)) begin
            n_cmp++;
            if (duty_valid && period_err) begin
                n_bad++;
                $display("FAIL both_pulses: duty_valid=1 period_err=1 required exclusive");
            end else if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: valid=%0d err=%0d duty=%0d full=%0d, none required",
                         duty_valid, period_err, duty_out, full_on);
            end else begin
                e = q.pop_front();
                if (e.is_err != period_err || int'(duty_out) != e.duty || full_on != e.full) begin
                    n_bad++;
                    $display("FAIL result @%0t: got err=%0d duty=%0d full=%0d, required err=%0d duty=%0d full=%0d",
                             $time, period_err, duty_out, full_on, e.is_err, e.duty, e.full);
                end
            end
        end
    end

    initial begin
        int duties[8];
        int p;
        int h;
        duties = '{8, 11, 4, 12, 10, 5, 9, 11};

        // Reset values
        repeat (3) @(posedge clk_50M);
        #2;
        t_cur = 3;
        chk_outputs_zero("reset");
        release_reset();

        // Line held low: periodic 0% reports
        seg(1'b0, 880);

        // Generator-style directed stream
        foreach (duties[i]) begin
            per(duties[i] * 16, NOM);
            per(duties[i] * 16, NOM);
        end
        per(128, NOM);
        per(128, NOM);

        // Out-of-tolerance periods hold the previous result; 259/120 rounds 7.5 up
        repeat (3) per(100, 200);
        per(120, 259);
        per(120, 259);

        // Stuck high, then a duty-4 stream
        seg(1'b1, 700);
        seg(1'b0, 50);
        repeat (3) per(64, NOM);

        // 1-cycle glitch in the low phase of a duty-5 stream
        per(80, NOM);
`ifdef PWM_DEGLITCH_EN
        model_seg(1'b1, 80);
        model_seg(1'b0, 176);
`else
        model_seg(1'b1, 80);
        model_seg(1'b0, 40);
        model_seg(1'b1, 1);
        model_seg(1'b0, 135);
`endif
        drive_raw(1'b1, 80);
        drive_raw(1'b0, 40);
        drive_raw(1'b1, 1);
        drive_raw(1'b0, 135);
        per(80, NOM);
        per(80, NOM);

        // Reset 100 cycles into a duty-12 period, released in the low phase
        per(192, NOM);
        per(192, NOM);
        seg(1'b1, 100);
        reset  = 1'b1;
        in_rst = 1;
        #1;
        chk_outputs_zero("async_reset");
        chk("queue_at_reset", q.size(), 0);
        q.delete();
        seg(1'b1, 91);
        seg(1'b0, 28);
        release_reset();
        seg(1'b0, 36);
        repeat (3) per(192, NOM);

        // Randomized periods, mostly in tolerance
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(230, 251))
                                                         : int'($urandom_range(261, 280));
                default: p = $urandom_range(NOM - TOL, NOM + TOL);
            endcase
            h = $urandom_range(3, p - 3);
            per(h, p);
        end

        seg(1'b0, 600);
        repeat (10) @(posedge clk_50M);
        #2;
        chk("pending_expected", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive side of the PWM generator: samples a fixed-period PWM line on clk_50M and recovers the 4-bit duty code that produced it.
- Generator timing is 16 steps of 320 ns, i.e. 16 cycles per step and a 256-cycle period at 50 MHz.
- Sits on the control board between the motor/LED PWM line and the command-readback and self-test logic.
- Reports one duty code per PWM period, flags malformed periods and handles constant-level (0%/100%) lines.

Parameters:
- PERIOD_CYC, 256: nominal PWM period in clk_50M cycles.
- STEP_CYC, 16: cycles per duty step; must be a power of two.
- TOL_CYC, 4: allowed period deviation (+/-) before a period is rejected.
- SYNC_STAGES, 2: synchronizer flops on pwm_in; legal range 2..3.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- pwm_in  in  1  PWM line, asynchronous to clk_50M.
- duty_out  out  4  last accepted duty code.
- full_on  out  1  1 when the last accepted result was a stuck-high line.
- duty_valid  out  1  single-cycle pulse: duty_out/full_on updated this cycle.
- period_err  out  1  single-cycle pulse: measured period out of tolerance, result discarded.

Behaviour:
- Reset (async assert, sync release): duty_out=0, full_on=0, duty_valid=0, period_err=0, counters=0, sync flops=0, state=IDLE.
- Input path:
  - pwm_in passes through SYNC_STAGES flops, then a 1-flop edge detector giving rise/fall pulses on sync'd level s.
- Counters:
  - hi_cnt and per_cnt are 9 bits wide and saturate at all-ones; they never wrap.
  - hi_cnt counts cycles with s=1 since the last rise.
  - per_cnt counts all cycles since the last rise.
- State IDLE (also used for no-edge operation):
  - Waits for a rise, then goes to MEAS with both counters cleared to 1.
  - If no rise occurs for PERIOD_CYC+TOL_CYC cycles, emit a level result and restart the timeout:
    - s=0: duty_out=0, full_on=0, duty_valid pulse.
    - s=1: duty_out=15, full_on=1, duty_valid pulse.
- State MEAS: counters run until the next rise, then evaluate.
  - Period check: accept if |per_cnt − PERIOD_CYC| ≤ TOL_CYC.
  - Accepted period:
    - duty = (hi_cnt + STEP_CYC/2) / STEP_CYC, computed in 9 bits.
    - Clamp 16 to 15.
    - Load duty_out, clear full_on, pulse duty_valid.
  - Rejected period: pulse period_err; duty_out and full_on hold.
  - Either way, clear counters to 1 and stay in MEAS.
- Timeout in MEAS:
  - per_cnt reaching PERIOD_CYC+TOL_CYC with no rise means the line stopped toggling.
  - Emit the level result exactly as in IDLE, then go to IDLE with the timeout counter cleared.
- Latency: duty_valid/period_err rise SYNC_STAGES+1 cycles after the pwm_in rising edge that closes the period.
- duty_valid and period_err are never high in the same cycle.
- First rise after reset or after IDLE only opens a measurement; no result is produced for it.
- Reset mid-period: the partial measurement is discarded, and the first result needs two rises after release.

Optional Feature:
- Macro: PWM_DEGLITCH_EN.
- Defined:
  - s changes only after 3 consecutive equal synchronized samples; rejects pulses of 1–2 cycles.
  - Adds 2 cycles to the latency; high time is unchanged because the delay applies to both edges.
- Undefined: s is the raw synchronizer output and a 1-cycle glitch is treated as a real edge.

Decomposition:
- Package pwm_dec_pkg holds:
  - state enum {IDLE, MEAS};
  - CNT_W=9;
  - localparams for TIMEOUT_CYC = PERIOD_CYC+TOL_CYC and for the half-step rounding constant.
- Sub-module pwm_in_sync: synchronizer, optional deglitch, edge detect.
  - Outputs s, rise, fall.
  - The top-level holds the FSM, the counters and the result registers.

Test Plan:
- Generator-style stimulus, 256-cycle period, duty 8, 11, 4, 12, 10, 5, 9, 11 (high time = duty×16 cycles), 2 periods each.
  - Required: one duty_valid per period from the second rise on; duty_out equals the stimulus code; period_err never pulses.
- pwm_in held 0 after reset.
  - Required: duty_valid at cycle 260+SYNC_STAGES (approx.) with duty_out=0, full_on=0, then again every 260 cycles.
- pwm_in held 1.
  - Required: duty_valid pulses with duty_out=15, full_on=1.
  - Then restart a duty-4 stream: the first valid result is duty_out=4 with full_on=0.
- Period 200 cycles, high 100.
  - Required: period_err pulse each period; duty_out keeps its previous value (e.g. 8).
  - Period 259 with high 120 (inside tolerance): accepted, duty_out=8 (rounding 7.5 up).
- Assert reset 100 cycles into a duty-12 period.
  - Required: all outputs 0 immediately (asynchronous); no valid until the second rise after release; then duty_out=12.
- 1-cycle high glitch inside a low phase of a duty-5 stream.
  - Macro undefined: period_err pulse.
  - Macro defined: glitch ignored, duty_out=5.
